// File: rtl/karatsuba_mult_stream.sv
// Fully pipelined Karatsuba-Ofman multiplier/squarer with a registered 2-entry input skid buffer.
// Sub-multipliers are recursive instances of this module that run off the top-level enable.
module karatsuba_mult_stream #(
    parameter int BITS     = 381,
    parameter int CTL_BITS = 8,
    parameter int LEVEL    = 2,
    parameter bit USE_SKID = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [BITS-1:0]     i_dat_a,
    input  logic [BITS-1:0]     i_dat_b,
    input  logic                i_sqr,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [2*BITS-1:0]   o_dat,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_val,
    input  logic                i_rdy
);
    localparam int H   = (BITS + 1) / 2;
    localparam int PW  = 2 * H;
    localparam int MW  = 2 * H + 2;
    localparam int RW  = 4 * H + 2;
    localparam int OW  = 2 * BITS;
    localparam int DEP = 3 * LEVEL;
    localparam int SW  = 2 * BITS + CTL_BITS;

    logic                en;
    logic [BITS-1:0]     p_a;
    logic [BITS-1:0]     p_b;
    logic [CTL_BITS-1:0] p_ctl;
    logic                p_val;

    // Inner instances receive the parent's enable on i_rdy.
    assign en = USE_SKID ? (~o_val | i_rdy) : i_rdy;

    if (USE_SKID) begin : g_skid
        logic [SW-1:0] slot [2];
        logic [1:0]    cnt;
        logic [1:0]    cnt_nxt;
        logic          wr_ptr;
        logic          rd_ptr;
        logic          rdy_q;
        logic          push;
        logic          pop;

        assign push    = i_val & rdy_q;
        assign pop     = en & (cnt != 2'd0);
        assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                rdy_q  <= 1'b0;
            end else begin
                cnt   <= cnt_nxt;
                rdy_q <= (cnt_nxt < 2'd2);
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end

        always_ff @(posedge i_clk) begin
            if (push) slot[wr_ptr] <= {i_dat_a, (i_sqr ? i_dat_a : i_dat_b), i_ctl};
        end

        assign {p_a, p_b, p_ctl} = slot[rd_ptr];
        assign p_val = pop;
        assign o_rdy = rdy_q;
    end else begin : g_bypass
        assign p_a   = i_dat_a;
        assign p_b   = i_sqr ? i_dat_a : i_dat_b;
        assign p_ctl = i_ctl;
        assign p_val = i_val;
        assign o_rdy = 1'b1;
    end

    logic [DEP-1:0]      val_sr;
    logic [CTL_BITS-1:0] ctl_sr [DEP];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val_sr <= '0;
        end else if (en) begin
            val_sr <= {val_sr[DEP-2:0], p_val};
        end
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            ctl_sr[0] <= p_ctl;
            for (int i = 1; i < DEP; i++) ctl_sr[i] <= ctl_sr[i-1];
        end
    end

    assign o_val = val_sr[DEP-1];
    assign o_ctl = ctl_sr[DEP-1];

    // Stage 1: split into halves, magnitudes of the half differences and the product sign.
    logic [H-1:0] al_c, ah_c, bl_c, bh_c;
    logic [H-1:0] a_lo, a_hi, b_lo, b_hi, a_df, b_df;
    logic         sgn1;

    assign al_c = p_a[H-1:0];
    assign ah_c = H'(p_a >> H);
    assign bl_c = p_b[H-1:0];
    assign bh_c = H'(p_b >> H);

    always_ff @(posedge i_clk) begin
        if (en) begin
            a_lo <= al_c;
            a_hi <= ah_c;
            b_lo <= bl_c;
            b_hi <= bh_c;
            a_df <= (ah_c < al_c) ? (al_c - ah_c) : (ah_c - al_c);
            b_df <= (bh_c < bl_c) ? (bl_c - bh_c) : (bh_c - bl_c);
            sgn1 <= (ah_c < al_c) ^ (bh_c < bl_c);
        end
    end

    logic [PW-1:0] m0, m1, m2;
    logic          sgn_m;
    logic [MW-1:0] mid_c;
    logic [PW-1:0] f0, f2;
    logic [MW-1:0] fmid;

    // Sign set means the signed half-difference product is negative, so m1 is added back.
    assign mid_c = sgn_m ? (MW'(m0) + MW'(m2) + MW'(m1)) : (MW'(m0) + MW'(m2) - MW'(m1));

    if (LEVEL == 1) begin : g_leaf
        always_ff @(posedge i_clk) begin
            if (en) begin
                m0    <= PW'(a_hi) * PW'(b_hi);
                m1    <= PW'(a_df) * PW'(b_df);
                m2    <= PW'(a_lo) * PW'(b_lo);
                sgn_m <= sgn1;
            end
        end
        assign f0   = m0;
        assign f2   = m2;
        assign fmid = mid_c;
    end else begin : g_rec
        localparam int D2 = 3 * (LEVEL - 1);

        logic [2:0]    unused_rdy;
        logic [2:0]    unused_ctl;
        logic [2:0]    unused_val;
        logic [D2-1:0] sgn_sr;
        logic [PW-1:0] m0_q, m2_q;
        logic [MW-1:0] mid_q;

        karatsuba_mult_stream #(
            .BITS(H), .CTL_BITS(1), .LEVEL(LEVEL - 1), .USE_SKID(1'b0)
        ) u_m0 (
            .i_clk(i_clk), .i_rst(i_rst), .i_dat_a(a_hi), .i_dat_b(b_hi), .i_sqr(1'b0),
            .i_ctl(1'b0), .i_val(1'b0), .o_rdy(unused_rdy[0]), .o_dat(m0),
            .o_ctl(unused_ctl[0]), .o_val(unused_val[0]), .i_rdy(en)
        );

        karatsuba_mult_stream #(
            .BITS(H), .CTL_BITS(1), .LEVEL(LEVEL - 1), .USE_SKID(1'b0)
        ) u_m1 (
            .i_clk(i_clk), .i_rst(i_rst), .i_dat_a(a_df), .i_dat_b(b_df), .i_sqr(1'b0),
            .i_ctl(1'b0), .i_val(1'b0), .o_rdy(unused_rdy[1]), .o_dat(m1),
            .o_ctl(unused_ctl[1]), .o_val(unused_val[1]), .i_rdy(en)
        );

        karatsuba_mult_stream #(
            .BITS(H), .CTL_BITS(1), .LEVEL(LEVEL - 1), .USE_SKID(1'b0)
        ) u_m2 (
            .i_clk(i_clk), .i_rst(i_rst), .i_dat_a(a_lo), .i_dat_b(b_lo), .i_sqr(1'b0),
            .i_ctl(1'b0), .i_val(1'b0), .o_rdy(unused_rdy[2]), .o_dat(m2),
            .o_ctl(unused_ctl[2]), .o_val(unused_val[2]), .i_rdy(en)
        );

        always_ff @(posedge i_clk) begin
            if (en) begin
                sgn_sr <= {sgn_sr[D2-2:0], sgn1};
                m0_q   <= m0;
                m2_q   <= m2;
                mid_q  <= mid_c;
            end
        end

        assign sgn_m = sgn_sr[D2-1];
        assign f0    = m0_q;
        assign f2    = m2_q;
        assign fmid  = mid_q;
    end

    logic [OW-1:0] dat_q;

    // Bits above 2*BITS are always zero for in-range operands, so truncation is exact.
    always_ff @(posedge i_clk) begin
        if (en) dat_q <= OW'((RW'(f0) << (2 * H)) + (RW'(fmid) << H) + RW'(f2));
    end

    assign o_dat = dat_q;

endmodule

// File: tb/tb_karatsuba_mult_stream.sv
// Self-checking bench: plain wide-integer product model with an in-order scoreboard,
// plus directed vectors whose results are pinned by hand-computed literals.
module tb_karatsuba_mult_stream;
    localparam int W   = 381;
    localparam int CW  = 8;
    localparam int LV  = 3;
    localparam int HW  = 191;
    localparam int LAT = 3 * LV + 1;

    typedef logic [2*W-1:0] prod_t;
    typedef logic [W-1:0]   opnd_t;
    typedef struct {
        prod_t         dat;
        logic [CW-1:0] ctl;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_sqr = 1'b0;
    logic          i_val = 1'b0;
    logic          i_rdy = 1'b1;
    opnd_t         i_dat_a = '0;
    opnd_t         i_dat_b = '0;
    logic [CW-1:0] i_ctl = '0;
    logic          o_rdy;
    logic          o_val;
    logic [CW-1:0] o_ctl;
    prod_t         o_dat;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          rst_d = 1'b1;
    bit            rdy_rand = 1'b0;
    exp_t          exp_q[$];
    int            occ = 0;
    logic          held = 1'b0;
    prod_t         hold_dat;
    logic [CW-1:0] hold_ctl;
    logic [CW-1:0] tag = '0;

    karatsuba_mult_stream #(.BITS(W), .CTL_BITS(CW), .LEVEL(LV)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_sqr(i_sqr),
        .i_ctl(i_ctl), .i_val(i_val), .o_rdy(o_rdy), .o_dat(o_dat), .o_ctl(o_ctl),
        .o_val(o_val), .i_rdy(i_rdy)
    );

    always #5 clk = ~clk;

    function automatic prod_t model(input opnd_t a, input opnd_t b, input logic sqr);
        prod_t x;
        prod_t y;
        x = prod_t'(a);
        y = sqr ? prod_t'(a) : prod_t'(b);
        return x * y;
    endfunction

    function automatic opnd_t mk(input opnd_t hi, input opnd_t lo);
        return (hi << HW) | lo;
    endfunction

    function automatic opnd_t rnd();
        opnd_t x;
        x = '0;
        for (int i = 0; i < 12; i++) x = (x << 32) | opnd_t'($urandom);
        if ($urandom_range(0, 15) == 0) x = '1;
        return x;
    endfunction

    task automatic chk(input string nm, input prod_t got, input prod_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        rst_d <= i_rst;
        cyc   <= cyc + 1;
    end

    // Scoreboard: checks reset state, o_rdy against occupancy, stall stability and every output.
    always @(negedge clk) begin
        logic push;
        logic pop;
        if (rst_d) begin
            chk("rst_oval", prod_t'(o_val), '0);
            chk("rst_ordy", prod_t'(o_rdy), '0);
        end else begin
            chk("ordy", prod_t'(o_rdy), prod_t'(occ < 2));
            if (held) begin
                chk("hold_val", prod_t'(o_val), prod_t'(1));
                chk("hold_dat", o_dat, hold_dat);
                chk("hold_ctl", prod_t'(o_ctl), prod_t'(hold_ctl));
            end
            if (o_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got output with tag %h, want no output", o_ctl);
                end else begin
                    chk("dat", o_dat, exp_q[0].dat);
                    chk("ctl", prod_t'(o_ctl), prod_t'(exp_q[0].ctl));
                    if (i_rdy) void'(exp_q.pop_front());
                end
            end
        end
        if (i_rst) begin
            exp_q.delete();
            occ  = 0;
            held = 1'b0;
        end else begin
            push = i_val && o_rdy;
            pop  = (!o_val || i_rdy) && (occ > 0);
            if (push) exp_q.push_back('{model(i_dat_a, i_dat_b, i_sqr), i_ctl});
            occ      = occ + int'(push) - int'(pop);
            held     = o_val && !i_rdy;
            hold_dat = o_dat;
            hold_ctl = o_ctl;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input opnd_t a, input opnd_t b, input logic sqr);
        int   n;
        logic t;
        n = 0;
        i_dat_a = a;
        i_dat_b = b;
        i_sqr   = sqr;
        i_ctl   = tag;
        i_val   = 1'b1;
        do begin
            @(negedge clk);
            t = o_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!t && n < 200);
        chk("send_accept", prod_t'(t), prod_t'(1));
        tag++;
        i_val = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_val && n < 100);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, prod_t'(exp_q.size()), '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        opnd_t         a;
        opnd_t         b;
        prod_t         lit;
        logic [CW-1:0] t_ctl;
        int            n;
        int            t0;

        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // All-ones 256-bit operands: (2^256-1)^2 = 2^512 - 2^257 + 1, plus latency.
        a   = '0;
        a[255:0] = '1;
        lit = {250'b0, {255{1'b1}}, 256'b0, 1'b1};
        chk("pin_ones", model(a, a, 1'b0), lit);
        t_ctl = tag;
        send(a, a, 1'b0);
        wait_out(n);
        chk("latency", prod_t'(n), prod_t'(LAT));
        chk("ones_dat", o_dat, lit);
        chk("ones_ctl", prod_t'(o_ctl), prod_t'(t_ctl));
        drain("drain_ones");

        // Squaring ignores operand B.
        a   = opnd_t'(32'h1234_5678);
        b   = opnd_t'(32'hFFFF_FFFF);
        lit = prod_t'(64'h014B_66DC_1DF4_D840);
        chk("pin_sqr", model(a, b, 1'b1), lit);
        send(a, b, 1'b1);
        wait_out(n);
        chk("sqr_dat", o_dat, lit);
        drain("drain_sqr");

        // Sign-path combinations at the top split plus equal halves at inner splits.
        lit = prod_t'(48'h2_0004_0002);
        chk("pin_eqh", model(opnd_t'(32'h0001_0001), opnd_t'(32'h0002_0002), 1'b0), lit);
        send(opnd_t'(32'h0001_0001), opnd_t'(32'h0002_0002), 1'b0);
        send(mk(5, 1000), mk(999, 7), 1'b0);
        send(mk(1000, 5), mk(7, 999), 1'b0);
        send(mk(5, 1000), mk(7, 999), 1'b0);
        send(mk(1000, 5), mk(999, 7), 1'b0);
        send(mk(123, 123), mk(77, 77), 1'b0);
        send(mk(123, 123), mk(77, 78), 1'b0);
        send('1, '1, 1'b0);
        send('0, '1, 1'b0);
        send(mk('1 >> (HW + 1), '1 >> (W - HW)), mk(1, '1 >> (W - HW)), 1'b0);
        drain("drain_sign");

        // Back-to-back streaming at full rate.
        t0 = cyc;
        for (int i = 0; i < 200; i++) send(rnd(), rnd(), 1'($urandom_range(0, 3) == 0));
        drain("drain_stream");
        chk("stream_rate", prod_t'((cyc - t0) <= 200 + LAT + 3), prod_t'(1));

        // Back-to-back inputs against a randomly stalling consumer.
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) send(rnd(), rnd(), 1'($urandom_range(0, 3) == 0));
        rdy_rand = 1'b0;
        drain("drain_stall");

        // Reset with five transactions in flight; none of them may emerge.
        for (int i = 0; i < 5; i++) send(rnd(), rnd(), 1'b0);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        repeat (LAT + 5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0);
        drain("drain_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/karatsuba_mult_stream.md
# karatsuba_mult_stream

Parametrised, fully pipelined Karatsuba-Ofman multiplier for the modular-arithmetic datapath. It computes a BITS x BITS unsigned product, or a square, from one shared recursive core and accepts one operation per clock. It adds three things over the existing fixed-power-of-two multiplier: arbitrary operand width, a per-transaction squaring mode, and a registered input skid buffer so that upstream `o_rdy` never depends combinationally on downstream `i_rdy`. It sits between the point-arithmetic sequencers and the modular reduction blocks.

## Interface
- BITS, 381: operand width; any value >= 2, odd values allowed
- CTL_BITS, 8: sideband tag width, carried unchanged from input to output
- LEVEL, 2: recursion depth, >= 1; LEVEL = 1 uses native `*` on the half-width operands
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high; clock i_clk
- i_dat_a  in  BITS  operand A, unsigned
- i_dat_b  in  BITS  operand B, unsigned; ignored when i_sqr = 1
- i_sqr  in  1  1 = output A*A
- i_ctl  in  CTL_BITS  tag
- i_val  in  1  input valid
- o_rdy  out  1  input ready; registered
- o_dat  out  2*BITS  product
- o_ctl  out  CTL_BITS  tag of o_dat
- o_val  out  1  output valid
- i_rdy  in  1  downstream ready

## Operation
- Input transfer happens when i_val & o_rdy. Output transfer happens when o_val & i_rdy.
- Skid buffer: 2 entries at the input, holding {a, b_eff, ctl}. b_eff = i_sqr ? i_dat_a : i_dat_b, selected on entry. o_rdy = (skid occupancy < 2), registered.
- Pipeline enable: en = ~o_val | i_rdy. Every stage, every recursive sub-instance, and every val/ctl delay line advances only on en. All sub-instances share the top-level en; they do not generate their own ready.
- A slot is popped from the skid buffer into the pipeline when en is high and the buffer is non-empty. Otherwise a bubble (val = 0) is inserted.
- Width rule: H = ceil(BITS/2). Operands are split into lo = x[H-1:0] and hi = the upper BITS-H bits, zero-extended to H.
- Sub-products: m0 = hi_a*hi_b and m2 = lo_a*lo_b, each 2H bits. m1 = |hi_a-lo_a| * |hi_b-lo_b|.
- Sign: s = (hi_a<lo_a) ^ (hi_b<lo_b), computed at the same stage as the magnitudes and delayed with the data.
- Middle term: mid = m0 + m2 - (s ? -m1 : m1). It is computed in 2H+2 bits and is never negative.
- Result: o_dat = (m0 << 2H) + (mid << H) + m2, truncated to 2*BITS. The truncated bits are provably zero.
- Recursion: sub-multipliers are instances of this module with BITS = H (or H+1 if needed for the magnitude path), LEVEL-1, i_sqr tied to 0, and their skid buffer bypassed (parameter-internal). When i_sqr = 1 the m0 and m2 sub-products are a squaring of each half; the tie-off is still legal because b_eff already equals a.
- o_ctl and the val bit travel in a shift register of depth 3*LEVEL alongside the data.

## Timing
- Pipeline latency: 3*LEVEL cycles from skid pop to o_val, plus 1 cycle through the skid buffer. Minimum input-to-output is 3*LEVEL+1 cycles.
- Throughput: 1 result per clock while i_rdy = 1.
- While o_val & ~i_rdy: the whole pipeline freezes, o_dat/o_ctl/o_val hold stable, and the skid buffer absorbs up to 2 further inputs. o_rdy falls the cycle after the second entry is written.
- When i_rdy returns: the pipeline resumes on that same edge, and o_rdy rises the cycle after the first pop.
- Simultaneous push and pop with the buffer full: the pop frees a slot, but o_rdy stays 0 for that cycle (registered). No data is lost or duplicated.
- Reset: on the first edge with i_rst = 1, o_val = 0, o_rdy = 0, skid occupancy = 0, and all val bits = 0. The first cycle after reset deasserts has o_rdy = 1.
- o_dat and o_ctl are not reset; they are don't-care while o_val = 0.
- Reset mid-operation discards all in-flight transactions; no output appears for them.

## Test plan
- BITS=256, LEVEL=2, a = b = 2^256-1 -> o_dat = 2^512 - 2^257 + 1 after 7 cycles, o_ctl matches the input tag.
- BITS=381 (odd), LEVEL=3, 10k random a,b with streaming i_val = 1 and i_rdy = 1 -> every o_dat = a*b, in order, one per clock after 10 cycles.
- i_sqr = 1, a = 0x1234_5678, i_dat_b = 0xFFFF_FFFF, BITS=32, LEVEL=1 -> o_dat = 0x014B_66DC_1DF4_D840, i.e. i_dat_b is ignored.
- Random i_rdy toggling at 50% with back-to-back inputs -> no drops or duplicates, o_rdy never high while the skid buffer is full, o_dat is stable while o_val & ~i_rdy.
- Sign-path cases lo_a>hi_a with lo_b<hi_b, and all 4 combinations including equal halves (a = 0x0001_0001, b = 0x0002_0002) -> exact products.
- Assert i_rst for 1 cycle with 5 transactions in flight -> o_val = 0 on the next cycle, none of the 5 tags appear, o_rdy = 1 the cycle after reset deasserts.
